// File: rtl/svm_ref_gen.sv
// rtl/svm_ref_gen.sv - inverse Clarke with min-max injection, Q1.15 saturation, period-aligned double buffer
module svm_ref_gen #(
  parameter int D_WIDTH = 16,
  parameter int Q_BITS  = 13
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [D_WIDTH-1:0] alpha,
  input  logic [D_WIDTH-1:0] beta,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               svm_done,
  output logic [D_WIDTH-1:0] vA,
  output logic [D_WIDTH-1:0] vB,
  output logic [D_WIDTH-1:0] vC,
  output logic               out_valid,
  output logic               sat
);

  localparam int W  = D_WIDTH + 2;
  localparam int SH = D_WIDTH - 1 - Q_BITS;
  localparam int RW = W + SH;
  localparam int PW = 2 * D_WIDTH + 2;
  localparam longint K_L = (64'sd866025404 * (64'sd1 <<< Q_BITS) + 64'sd500000000) / 64'sd1000000000;
  localparam logic [D_WIDTH-1:0] K = D_WIDTH'(K_L);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_PHASE, S_INJ, S_COMMIT} state_t;

  state_t state, state_n;

  logic [D_WIDTH-1:0] alpha_q, beta_q;
  logic signed [W-1:0] ps, va, vb, vc;
  logic [D_WIDTH-1:0] pend_a, pend_b, pend_c;
  logic               pend_s, pend;

  always_ff @(posedge clk) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (in_valid) state_n = S_MUL;
      S_MUL:    state_n = S_PHASE;
      S_PHASE:  state_n = S_INJ;
      S_INJ:    state_n = S_COMMIT;
      S_COMMIT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign in_ready = rstb && (state == S_IDLE);

  // Taking bits [Q_BITS +: W] of the product is the floor shift, truncated to W.
  logic [PW-1:0]       p_u;
  logic signed [W-1:0] ps_n, ax, h;
  assign p_u  = {{(D_WIDTH+2){beta_q[D_WIDTH-1]}}, beta_q} * {{(D_WIDTH+2){1'b0}}, K};
  assign ps_n = p_u[Q_BITS +: W];
  assign ax   = {{2{alpha_q[D_WIDTH-1]}}, alpha_q};
  assign h    = ax >>> 1;

  logic signed [W-1:0] mx, mn, vo;
  logic signed [W:0]   sum;
  always_comb begin
    mx = va;
    mn = va;
    if (vb > mx) mx = vb;
    if (vc > mx) mx = vc;
    if (vb < mn) mn = vb;
    if (vc < mn) mn = vc;
  end
  assign sum = {mx[W-1], mx} + {mn[W-1], mn};
  assign vo  = -(sum[W:1]);

  function automatic logic [D_WIDTH:0] clip(input logic signed [W-1:0] v);
    logic signed [RW-1:0] r;
    r = RW'(v) <<< SH;
    if (r[RW-1:D_WIDTH-1] == {(RW-D_WIDTH+1){r[RW-1]}})
      return {1'b0, r[D_WIDTH-1:0]};
    return {1'b1, r[RW-1], {(D_WIDTH-1){~r[RW-1]}}};
  endfunction

  logic [D_WIDTH:0] ca, cb, cc;
  logic             s_n;
  assign ca  = clip(va);
  assign cb  = clip(vb);
  assign cc  = clip(vc);
  assign s_n = ca[D_WIDTH] | cb[D_WIDTH] | cc[D_WIDTH];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      alpha_q <= '0; beta_q <= '0;
      ps <= '0; va <= '0; vb <= '0; vc <= '0;
      vA <= '0; vB <= '0; vC <= '0; sat <= 1'b0; out_valid <= 1'b0;
      pend_a <= '0; pend_b <= '0; pend_c <= '0; pend_s <= 1'b0; pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) begin alpha_q <= alpha; beta_q <= beta; end
        S_MUL:   ps <= ps_n;
        S_PHASE: begin va <= ax; vb <= ps - h; vc <= -h - ps; end
        S_INJ:   begin va <= va + vo; vb <= vb + vo; vc <= vc + vo; end
        default: ;
      endcase
      // A fresh result bypasses the buffer whenever svm is not mid-period.
      if (state == S_COMMIT) begin
        out_valid <= 1'b1;
        if (!out_valid || svm_done) begin
          vA <= ca[D_WIDTH-1:0]; vB <= cb[D_WIDTH-1:0]; vC <= cc[D_WIDTH-1:0];
          sat <= s_n; pend <= 1'b0;
        end else begin
          pend_a <= ca[D_WIDTH-1:0]; pend_b <= cb[D_WIDTH-1:0]; pend_c <= cc[D_WIDTH-1:0];
          pend_s <= s_n; pend <= 1'b1;
        end
      end else if (svm_done && pend) begin
        vA <= pend_a; vB <= pend_b; vC <= pend_c; sat <= pend_s; pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svm_ref_gen.sv
// tb/tb_svm_ref_gen.sv - directed table and sequence checks for svm_ref_gen
module tb_svm_ref_gen;
  logic        clk = 1'b0;
  logic        rstb, in_valid, svm_done;
  logic [15:0] alpha, beta;
  logic        in_ready, out_valid, sat;
  logic [15:0] vA, vB, vC;

  int n_pass = 0;
  int n_tot  = 0;

  svm_ref_gen #(.D_WIDTH(16), .Q_BITS(13)) dut (
    .clk(clk), .rstb(rstb), .alpha(alpha), .beta(beta), .in_valid(in_valid),
    .in_ready(in_ready), .svm_done(svm_done), .vA(vA), .vB(vB), .vC(vC),
    .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, ea, eb, ec;
    logic        es;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string name, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] ec, input logic es);
    chk({name, ".vA"}, {16'h0, vA}, {16'h0, ea});
    chk({name, ".vB"}, {16'h0, vB}, {16'h0, eb});
    chk({name, ".vC"}, {16'h0, vC}, {16'h0, ec});
    chk({name, ".sat"}, {31'h0, sat}, {31'h0, es});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at edge 0, drive svm_done during the COMMIT cycle, return in cycle 5.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic done,
                         input logic chk_pre);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("ready_wait", {31'h0, in_ready}, 32'h1);
    alpha = a; beta = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alpha = 16'h5a5a; beta = 16'ha5a5;
    for (int c = 1; c <= 4; c++) begin
      if (chk_pre) begin
        chk("pre.out_valid", {31'h0, out_valid}, 32'h0);
        chk("pre.in_ready", {31'h0, in_ready}, 32'h0);
        chk("pre.vA", {16'h0, vA}, 32'h0);
      end
      if (c == 4) svm_done = done;
      step();
    end
    svm_done = 1'b0;
  endtask

  task automatic pulse_done();
    svm_done = 1'b1;
    step();
    svm_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{16'h1000, 16'h0000, 16'h3000, 16'hD000, 16'hD000, 1'b0};
    tbl[1]  = '{16'h0000, 16'h1000, 16'h0000, 16'h376C, 16'hC894, 1'b0};
    tbl[2]  = '{16'h3FFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 1'b1};
    tbl[3]  = '{16'hF000, 16'h0000, 16'hD000, 16'h3000, 16'h3000, 1'b0};
    tbl[4]  = '{16'h0000, 16'hF000, 16'h0000, 16'hC894, 16'h376C, 1'b0};
    tbl[5]  = '{16'hC000, 16'h0000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b1};
    tbl[6]  = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFC, 16'h0004, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'h0000, 16'hFFFC, 16'h0004, 16'h0004, 1'b0};
    tbl[8]  = '{16'h2AA9, 16'h0000, 16'h7FFC, 16'h8008, 16'h8008, 1'b0};
    tbl[9]  = '{16'h2AAA, 16'h0000, 16'h7FFF, 16'h8004, 16'h8004, 1'b1};
    tbl[10] = '{16'h0001, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 1'b0};

    rstb = 1'b0; in_valid = 1'b0; svm_done = 1'b0; alpha = '0; beta = '0;
    step(); step();
    chk("rst.in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk_out("rst", 16'h0, 16'h0, 16'h0, 1'b0);
    rstb = 1'b1;
    step();
    chk("rel.in_ready", {31'h0, in_ready}, 32'h1);

    run_cmd(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("zero.out_valid", {31'h0, out_valid}, 32'h1);
    chk("zero.in_ready", {31'h0, in_ready}, 32'h1);
    chk_out("zero", 16'h0, 16'h0, 16'h0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
      chk_out($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].es);
    end

    run_cmd(16'h1000, 16'h0000, 1'b1, 1'b0);
    chk_out("db.first", 16'h3000, 16'hD000, 16'hD000, 1'b0);
    run_cmd(16'h0000, 16'h1000, 1'b0, 1'b0);
    chk_out("db.held2", 16'h3000, 16'hD000, 16'hD000, 1'b0);
    run_cmd(16'h0000, 16'h0000, 1'b0, 1'b0);
    chk_out("db.held3", 16'h3000, 16'hD000, 16'hD000, 1'b0);
    svm_done = 1'b1;
    chk_out("db.pulse_cycle", 16'h3000, 16'hD000, 16'hD000, 1'b0);
    step();
    svm_done = 1'b0;
    chk_out("db.swap", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    pulse_done();
    chk_out("db.pulse2", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    run_cmd(16'h0000, 16'h1000, 1'b1, 1'b0);
    chk_out("db.coincide", 16'h0000, 16'h376C, 16'hC894, 1'b0);
    run_cmd(16'h3FFF, 16'h0000, 1'b0, 1'b0);
    chk_out("db.held_sat", 16'h0000, 16'h376C, 16'hC894, 1'b0);
    step(); step();
    chk_out("db.idle_hold", 16'h0000, 16'h376C, 16'hC894, 1'b0);
    pulse_done();
    chk_out("db.swap_sat", 16'h7FFF, 16'h8000, 16'h8000, 1'b1);

    alpha = 16'h1000; beta = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rstb = 1'b0;
    step();
    chk("mid.out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid.in_ready", {31'h0, in_ready}, 32'h0);
    chk_out("mid", 16'h0, 16'h0, 16'h0, 1'b0);
    rstb = 1'b1;
    step();
    chk("mid.rel_ready", {31'h0, in_ready}, 32'h1);
    for (int c = 0; c < 6; c++) step();
    chk("mid.no_ghost_valid", {31'h0, out_valid}, 32'h0);
    chk("mid.no_ghost_vA", {16'h0, vA}, 32'h0);
    run_cmd(16'h0000, 16'h1000, 1'b0, 1'b1);
    chk("mid.after_valid", {31'h0, out_valid}, 32'h1);
    chk_out("mid.after", 16'h0000, 16'h376C, 16'hC894, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/svm_ref_gen.md
# svm_ref_gen

Upstream reference stage for `svm`. Accepts a stationary-frame voltage command (alpha, beta), runs an inverse Clarke transform with min-max (zero-sequence) injection, and scales and saturates the three phase references into the signed Q1.15 format `svm` consumes on `vA/vB/vC`. Holds a double-buffered command, so phase references change only at a PWM-period boundary, signalled by `svm`'s `out_valid` pulse.

## Interface
- `D_WIDTH`, 16: data width of all command and reference words.
- `Q_BITS`, 13: fractional bits of `alpha`/`beta`. Output shift is `D_WIDTH-1-Q_BITS`. The constraint `Q_BITS <= D_WIDTH-1` holds.
- `clk` input 1: sole clock, rising edge.
- `rstb` input 1: reset, synchronous, active-low.
- `alpha` input D_WIDTH: signed Q(D_WIDTH-Q_BITS).Q_BITS alpha-axis command.
- `beta` input D_WIDTH: signed, same format, beta-axis command.
- `in_valid` input 1: command present.
- `in_ready` output 1: block can accept a command.
- `svm_done` input 1: one-cycle period-end pulse, driven by `svm.out_valid`.
- `vA`, `vB`, `vC` output D_WIDTH: signed Q1.15 phase references, driving `svm.vA/vB/vC`.
- `out_valid` output 1: level signal, driving `svm.in_valid`.
- `sat` output 1: the currently presented reference set was clipped.

## Operation
- FSM states: IDLE → MUL → PHASE → INJ → COMMIT → IDLE, with one cycle per state.
- IDLE
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `alpha` and `beta`, then go to MUL.
- MUL
  - `p = beta * K`, where `K = round(0.8660254 * 2^Q_BITS)`. K = 7094 at the defaults.
  - Product is 2*D_WIDTH signed. Register `ps = p >>> Q_BITS` (arithmetic shift, truncates toward −inf).
- PHASE: compute in D_WIDTH+2 signed bits:
  - `h = alpha >>> 1`
  - `va = alpha`
  - `vb = -h + ps`
  - `vc = -h - ps`
- INJ
  - `vo = -((max(va,vb,vc) + min(va,vb,vc)) >>> 1)`.
  - `vx' = vx + vo` for each phase.
- COMMIT
  - `rx = vx' <<< (D_WIDTH-1-Q_BITS)`.
  - Saturate `rx` to [−2^(D_WIDTH−1), 2^(D_WIDTH−1)−1].
  - `s` = 1 if any phase clipped.
  - Result {rA, rB, rC, s} goes to one of:
    - Outputs directly, if `out_valid` = 0, or if `svm_done` = 1 in this same cycle.
    - Otherwise the pending buffer, setting `pend` = 1. An existing pending entry is overwritten (latest wins).
- Period-boundary update: on `svm_done` with `pend` = 1 (and no simultaneous COMMIT), copy pending to `vA/vB/vC/sat` and clear `pend`. COMMIT in the same cycle takes precedence and also clears `pend`.
- `svm_done` with `pend` = 0 and no COMMIT: outputs unchanged.
- `svm_done` outside these cases is ignored, including while `out_valid` = 0.
- Once set, `out_valid` stays 1 until reset. `svm` re-runs the current references every period.
- `vA/vB/vC/sat` change only on the edges defined above. They must stay stable through `svm`'s read cycles.

## Timing
- Reset (`rstb` low at an edge): FSM to IDLE, and the following cleared:
  - `vA = vB = vC = 0`, `out_valid = 0`, `sat = 0`
  - `pend = 0`, pending buffer = 0, latched operands = 0.
- `in_ready` = 0 while `rstb` is low. It is 1 from the first cycle after release.
- Reset mid-computation discards the in-flight command. Reset overrides `svm_done` and COMMIT in the same cycle.
- Latency for a command accepted at edge 0:
  - COMMIT occupies cycle 4.
  - Direct-path outputs and `out_valid` are visible in cycle 5. `in_ready` is also 1 again in cycle 5.
- Throughput: 1 command per 5 cycles. `in_valid` held high while `in_ready` = 0 is not consumed.
- Pending-path outputs are visible the cycle after the `svm_done` pulse, which is `svm`'s state-1 cycle.
- `in_valid` sampled only in IDLE; operand changes after acceptance are ignored.

## Test plan
- **Zero command:** reset, then `alpha` = 0, `beta` = 0 accepted at edge 0. Required: cycle 5 shows `vA = vB = vC` = 0x0000, `out_valid` = 1, `sat` = 0. Before that, all outputs are 0 and `out_valid` = 0.
- **Alpha only:** `alpha` = 4096, `beta` = 0. Required: `vA` = 0x3000, `vB` = `vC` = 0xD000, `sat` = 0.
- **Beta only:** `alpha` = 0, `beta` = 4096. Required: `vA` = 0x0000, `vB` = 0x376C, `vC` = 0xC894, `sat` = 0.
- **Saturation:** `alpha` = 16383, `beta` = 0. Required: `vA` = 0x7FFF, `vB` = `vC` = 0x8000, `sat` = 1.
- **Double buffering:**
  - First command gives `vA` = 0x3000.
  - Second command (`alpha` = 0, `beta` = 4096) commits while `svm_done` = 0. Required: outputs unchanged.
  - Third command (`alpha` = 0, `beta` = 0) commits. Required: pending overwritten.
  - `svm_done` pulse. Required: next cycle shows 0/0/0, `pend` cleared.
  - Second pulse. Required: no change.
  - COMMIT coinciding with `svm_done`. Required: the new value appears directly.
- **Reset mid-operation:** assert `rstb` low during PHASE with `out_valid` = 1. Required:
  - Next cycle shows all outputs 0 and `out_valid` = 0.
  - The aborted command never appears.
  - `in_ready` = 1 the cycle after release.
